serial_adder: RTL

//  Bit-serial N-bit adder built around one full_adder cell and a carry flop.

---
 rtl/serial_adder.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Latency: start sampled at edge e0, done pulses in the cycle after edge e0+WIDTH.
// No backpressure: start is honoured only in IDLE; requests in RUN/DONE are dropped.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_fs;
  logic             w_fc;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nxt;

  // Full-adder cell on the current LSB pair and the fed-back carry.
  assign w_fs = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_fc = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  // Written as shift/or so it stays legal for WIDTH=1.
  assign w_sum_nxt = (r_sum_sh >> 1) | (WIDTH'(w_fs) << (WIDTH - 1));
  assign w_last    = (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (r_state == ST_RUN) || (r_state == ST_DONE);
    done = (r_state == ST_DONE);
  end

  // Datapath: load operands in IDLE, shift one bit pair per RUN cycle,
  // capture the result only on the final RUN edge so S/Cout hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      S        <= '0;
      Cout     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= A;
            r_b_sh  <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_sum_sh <= w_sum_nxt;
          r_carry  <= w_fc;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            S    <= w_sum_nxt;
            Cout <= w_fc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
